// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter driving the select of a 4:1 data mux; all outputs registered.
// Optional per-owner hold limit compiled in with `define MUX_ARB_HOLD_LIMIT_EN (uses MAX_HOLD).
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid
);

  localparam int NUM_REQ = 4;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux4_rr_arbiter: MAX_HOLD must be in 2..255");
  end

  state_t             state_q, state_d;
  logic [1:0]         last_q, last_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [1:0]         sel_d;
  logic               valid_d;
  logic [NUM_REQ-1:0] others;
  logic               pick_any;
  logic [1:0]         pick_idx;
  logic               new_grant;
  logic               hold_lim;

  // First set bit after 'from', wrapping; 'from' itself is checked last. Returns {found, idx}.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [1:0] from);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = from + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // While busy the current owner is excluded so a handover never re-picks it.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign others[i] = req[i] & ~(valid & (sel == 2'(i)));
  end

`ifdef MUX_ARB_HOLD_LIMIT_EN
  logic [7:0] hold_q, hold_d;

  assign hold_lim = (state_q == BUSY) && (hold_q == 8'(MAX_HOLD - 1));

  always_comb begin
    hold_d = 8'd0;
    if (state_d == BUSY && !new_grant && !hold_lim) hold_d = hold_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= 8'd0;
    else        hold_q <= hold_d;
  end
`else
  assign hold_lim = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt;
    sel_d     = sel;
    valid_d   = valid;
    last_d    = last_q;
    new_grant = 1'b0;
    {pick_any, pick_idx} = rr_pick(others, last_q);
    case (state_q)
      IDLE: begin
        if (pick_any) new_grant = 1'b1;
      end
      BUSY: begin
        if (!req[sel] || hold_lim) begin
          if (pick_any) begin
            new_grant = 1'b1;
          end else if (!req[sel]) begin
            state_d = IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
    if (new_grant) begin
      state_d = BUSY;
      gnt_d   = 4'b0001 << pick_idx;
      sel_d   = pick_idx;
      valid_d = 1'b1;
      last_d  = pick_idx;
    end
  end

  // last resets to 3 so requester 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt     <= '0;
      sel     <= 2'd0;
      valid   <= 1'b0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      valid   <= valid_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomized + directed bench for mux4_rr_arbiter against an integer-owner reference model.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;

  int n_tests = 0;
  int n_fail  = 0;

  // model: owner index or -1 when idle
  int m_owner, m_last, m_sel, m_hold;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .sel(sel), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int next_rr(input logic [3:0] r, input int from, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (from + k) % 4;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 3; m_sel = 0; m_hold = 0;
  endtask

  task automatic model_grant(input int i);
    m_owner = i; m_last = i; m_sel = i; m_hold = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    int n;
    if (m_owner < 0) begin
      n = next_rr(r, m_last, -1);
      if (n >= 0) model_grant(n);
    end else if (!r[m_owner]) begin
      n = next_rr(r, m_owner, m_owner);
      if (n >= 0) model_grant(n);
      else m_owner = -1;
    end else begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
      if (m_hold == MAX_HOLD - 1) begin
        n = next_rr(r, m_owner, m_owner);
        if (n >= 0) model_grant(n);
        else m_hold = 0;
      end else begin
        m_hold++;
      end
`endif
    end
  endtask

  task automatic compare(input string tag);
    check({tag, ".gnt"}, 32'(gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check({tag, ".valid"}, 32'(valid), 32'(m_owner >= 0));
    check({tag, ".sel"}, 32'(sel), 32'(m_sel));
    check({tag, ".onehot"}, 32'($countones(gnt) <= 1), 32'd1);
    if (valid) check({tag, ".selmatch"}, 32'(gnt), 32'(4'b0001 << sel));
  endtask

  // Called at posedge+1: outputs sampled 1 time unit after each edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_step(req);
    #1;
    compare(tag);
  endtask

  // Reset pulse between edges: outputs must clear before the next edge.
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare(tag);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2 compare("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 0101 -> grant 0, then drop 0 -> grant 2
    req = 4'b0101;
    step("r022a");
    check("r022a.gnt_const", 32'(gnt), 32'h1);
    req = 4'b0100;
    step("r022b");
    check("r022b.gnt_const", 32'(gnt), 32'h4);
    check("r022b.sel_const", 32'(sel), 32'd2);

    // all request, each owner keeps 2 cycles, order 0,1,2,3,0 with no bubble
    pulse_reset("r023rst");
    req = 4'b1111;
    step("r023");
    step("r023");
    for (int o = 1; o <= 4; o++) begin
      req = 4'b1111 & ~(4'b0001 << ((o - 1) % 4));
      step("r023");
      check("r023.order", 32'(gnt), 32'd1 << (o % 4));
      check("r023.nobubble", 32'(valid), 32'd1);
      req = 4'b1111;
      step("r023");
    end

    // req[3] for 3 cycles, idle, then 0001 grants 0
    pulse_reset("r024rst");
    req = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      step("r024");
      check("r024.gnt3", 32'(gnt), 32'h8);
    end
    req = 4'b0000;
    step("r024idle");
    check("r024.idle", 32'(valid), 32'd0);
    req = 4'b0001;
    step("r024wrap");
    check("r024.wrap", 32'(gnt), 32'h1);

    // req[1] and req[2] held: alternates every MAX_HOLD with the limit, else stays on 1
    pulse_reset("r025rst");
    req = 4'b0110;
    for (int c = 0; c < 12; c++) begin
      step("r025");
      if (c == 0) check("r025.first", 32'(gnt), 32'h2);
`ifdef MUX_ARB_HOLD_LIMIT_EN
      if (c == MAX_HOLD) check("r025.handover", 32'(gnt), 32'h4);
`else
      if (c == MAX_HOLD) check("r025.held", 32'(gnt), 32'h2);
`endif
    end

    // reset mid-busy clears outputs before the next edge
    req = 4'b0100;
    step("r026a");
    step("r026a");
    pulse_reset("r026rst");
    check("r026.rst_gnt", 32'(gnt), 32'd0);
    step("r026b");
    check("r026.regrant", 32'(gnt), 32'h4);

    // random traffic with occasional resets
    req = 4'($urandom_range(0, 15));
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 249) == 0) begin
        pulse_reset("rnd_rst");
      end else begin
        for (int b = 0; b < 4; b++)
          if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
        step("rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
